// File: rtl/mem_responder.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache in
// front of a multi-cycle backing memory. Read hits complete in the request cycle.
module mem_responder #(
  parameter int LINES    = 16,
  parameter int MEM_AW   = 10,
  parameter int MISS_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 15 - IDX_W;
  localparam int CNT_W = $clog2(MISS_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_LAT - 1);

  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, DONE_RD, DONE_WR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [15:0]        data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [15:0]        mem_q  [2**MEM_AW];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [MEM_AW-1:0]  mem_addr;
  logic               lookup_hit;
  logic               req_err;

  logic               done_c, stall_c, hit_c, err_c;
  logic [15:0]        data_c;
  logic               fill_en, mem_we, cache_we;

  // createdump is reserved and intentionally has no effect.
  logic unused;
  assign unused = createdump;

  assign idx        = Addr[IDX_W:1];
  assign tag        = Addr[15:IDX_W+1];
  assign mem_addr   = Addr[MEM_AW:1];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign req_err    = (Rd && Wr) || ((Rd || Wr) && Addr[0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    valid_d  = valid_q;
    done_c   = 1'b0;
    stall_c  = 1'b0;
    hit_c    = 1'b0;
    err_c    = 1'b0;
    data_c   = '0;
    fill_en  = 1'b0;
    mem_we   = 1'b0;
    cache_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_err) begin
          err_c  = 1'b1;
          done_c = 1'b1;
        end else if (Rd) begin
          if (lookup_hit) begin
            done_c = 1'b1;
            hit_c  = 1'b1;
            data_c = data_q[idx];
          end else begin
            stall_c = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = MEM_RD;
          end
        end else if (Wr) begin
          stall_c = 1'b1;
          hit_d   = lookup_hit;
          cnt_d   = CNT_LOAD;
          state_d = MEM_WR;
        end
      end
      MEM_RD, MEM_WR: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Leaving on count 1 makes the request cycle plus these cycles MISS_LAT long.
        if (cnt_q == CNT_W'(1)) state_d = (state_q == MEM_RD) ? DONE_RD : DONE_WR;
      end
      DONE_RD: begin
        done_c       = 1'b1;
        data_c       = mem_q[mem_addr];
        fill_en      = 1'b1;
        valid_d[idx] = 1'b1;
        state_d      = IDLE;
      end
      DONE_WR: begin
        done_c   = 1'b1;
        hit_c    = hit_q;
        mem_we   = 1'b1;
        cache_we = hit_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even if a request is still driven.
  assign Done     = done_c  & ~rst;
  assign Stall    = stall_c & ~rst;
  assign CacheHit = hit_c   & ~rst;
  assign err      = err_c   & ~rst;
  assign DataOut  = rst ? 16'h0000 : data_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: storage arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= mem_q[mem_addr];
      tag_q[idx]  <= tag;
    end
    if (cache_we) data_q[idx] <= DataIn;
    if (mem_we)   mem_q[mem_addr] <= DataIn;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues the expected response of each
// request and a negedge monitor pops and compares whenever Done is presented.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int stall_cnt   = 0;

  typedef struct {
    logic        hit;
    logic [15:0] data;
    logic        err;
    int          stall;
  } exp_t;
  exp_t exp_q[$];

  mem_responder dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: counts stall cycles and compares every completed response.
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
      if (Done) check("done_in_reset", 32'(Done), 32'd0);
    end else begin
      if (Stall) stall_cnt++;
      if (Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(Done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cache_hit",   32'(CacheHit), 32'(e.hit));
          check("data_out",    32'(DataOut),  32'(e.data));
          check("err",         32'(err),      32'(e.err));
          check("stall_at_done", 32'(Stall),  32'd0);
          check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic idle_inputs();
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
  endtask

  // Called just after a rising edge; returns just after the rising edge that ends Done.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] din, input logic ehit, input logic [15:0] edata,
                        input logic eerr, input int estall);
    exp_t e;
    e.hit = ehit; e.data = edata; e.err = eerr; e.stall = estall;
    exp_q.push_back(e);
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (Done) break;
      if (n == 20) begin
        check("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Issue a request and pull reset after 'cycles' rising edges, before it can complete.
  task automatic abort_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] din, input int cycles);
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_done",  32'(Done),     32'd0);
    check("abort_stall", 32'(Stall),    32'd0);
    check("abort_hit",   32'(CacheHit), 32'd0);
    check("abort_err",   32'(err),      32'd0);
    check("abort_data",  32'(DataOut),  32'd0);
    repeat (2) @(posedge clk);
    #1 idle_inputs();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    createdump = 1'b0;
    rst = 1'b1;
    // Drive an illegal request during reset: outputs must still read zero.
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0011; DataIn = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done",  32'(Done),     32'd0);
    check("rst_stall", 32'(Stall),    32'd0);
    check("rst_hit",   32'(CacheHit), 32'd0);
    check("rst_err",   32'(err),      32'd0);
    check("rst_data",  32'(DataOut),  32'd0);
    idle_inputs();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_done", 32'(Done), 32'd0);

    // Preload mem[8] through a write miss (no allocate).
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 4);
    // 1: read miss fills the line.
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 4);
    // 2: read hit, zero latency.
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 0);
    // 3: write hit updates cache and memory.
    do_req(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b1, 16'h0000, 1'b0, 4);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b0, 0);
    // 4: write miss to the same index leaves the cached line alone.
    do_req(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0, 16'h0000, 1'b0, 4);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b0, 0);
    do_req(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h5555, 1'b0, 4);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234, 1'b0, 4);
    // Address 0x0810 aliases memory word 8 but is a distinct cache tag.
    do_req(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b0, 16'h1234, 1'b0, 4);
    do_req(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b1, 16'h1234, 1'b0, 0);
    // 5: illegal requests complete immediately with err and change nothing.
    do_req(1'b1, 1'b1, 16'h0810, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 0);
    do_req(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 16'h0000, 1'b1, 0);
    do_req(1'b0, 1'b1, 16'h0813, 16'hAAAA, 1'b0, 16'h0000, 1'b1, 0);
    do_req(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b1, 16'h1234, 1'b0, 0);
    // 6: reset during a read miss, then during a write miss one cycle before Done.
    abort_req(1'b1, 1'b0, 16'h0050, 16'h0000, 2);
    abort_req(1'b0, 1'b1, 16'h0010, 16'hDEAD, 3);
    // Valid bits cleared and the aborted write never reached memory.
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234, 1'b0, 4);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
